wb_select_stage: RTL and testbench

- Parametrised register-file writeback select stage, sitting between the DM/EX-DM pipeline register and the register file.
- Selects one of NSRC result sources by priority and registers the chosen data, destination address and write enable into the DM/WB stage.
- Supports stall and flush.
- Adds a handshake for a variable-latency external ALU source: the stage waits for the result, raises a stall request while waiting, and flags a timeout.

---
 rtl/wb_select_stage.sv | 105 ++++++++++
 tb/tb_wb_select_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wb_select_stage.sv
// Writeback select stage: priority-picks one of NSRC results and registers
// it into DM/WB, with a wait/timeout handshake for a slow external ALU.
module wb_select_stage #(
  parameter int WIDTH   = 32,
  parameter int NSRC    = 6,
  parameter int AW      = 4,
  parameter int EXT_IDX = 3,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  we_in,
  input  logic [AW-1:0]         dst_addr_in,
  input  logic [NSRC-1:0]       src_sel,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic                  ext_valid,
  input  logic [WIDTH-1:0]      ext_data,
  output logic [WIDTH-1:0]      rf_w_data,
  output logic [AW-1:0]         rf_w_addr,
  output logic                  rf_we,
  output logic                  ext_wait,
  output logic                  ext_err
);

  localparam int IW = $clog2(NSRC);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic {
    PASS,
    WAIT_EXT
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   wait_cnt_q;
  logic            we_rec_q;
  logic [IW-1:0]   sel_idx;
  logic [WIDTH-1:0] sel_data;
  logic            is_ext;

  // Lowest set bit wins; an empty request falls back to source 0.
  always_comb begin
    sel_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_sel[i]) sel_idx = IW'(i);
    end
  end

  assign sel_data = src_data[int'(sel_idx) * WIDTH +: WIDTH];
  assign is_ext   = (sel_idx == IW'(EXT_IDX));

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_w_data  <= '0;
      rf_w_addr  <= '0;
      rf_we      <= 1'b0;
      ext_wait   <= 1'b0;
      ext_err    <= 1'b0;
      state_q    <= PASS;
      wait_cnt_q <= '0;
      we_rec_q   <= 1'b0;
    end else begin
      unique case (state_q)
        PASS: begin
          if (flush || stall) begin
            rf_we <= 1'b0;
          end else if (is_ext && !ext_valid) begin
            rf_w_addr  <= dst_addr_in;
            rf_we      <= 1'b0;
            ext_wait   <= 1'b1;
            wait_cnt_q <= '0;
            we_rec_q   <= we_in;
            state_q    <= WAIT_EXT;
          end else begin
            rf_w_data <= is_ext ? ext_data : sel_data;
            rf_w_addr <= dst_addr_in;
            rf_we     <= we_in;
          end
        end
        WAIT_EXT: begin
          if (flush) begin
            rf_we    <= 1'b0;
            ext_wait <= 1'b0;
            state_q  <= PASS;
          end else if (ext_valid) begin
            rf_w_data <= ext_data;
            rf_we     <= we_rec_q;
            ext_wait  <= 1'b0;
            state_q   <= PASS;
          end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
            ext_err  <= 1'b1;
            rf_we    <= 1'b0;
            ext_wait <= 1'b0;
            state_q  <= PASS;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: state_q <= PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage: directed and random stimulus, with
// expected outputs queued by a reference model and checked by a monitor.
module tb_wb_select_stage;

  localparam int WIDTH   = 32;
  localparam int NSRC    = 6;
  localparam int AW      = 4;
  localparam int EXT_IDX = 3;
  localparam int TIMEOUT = 16;

  logic                  clk = 1'b0;
  logic                  rst, stall, flush, we_in, ext_valid;
  logic [AW-1:0]         dst_addr_in;
  logic [NSRC-1:0]       src_sel;
  logic [NSRC*WIDTH-1:0] src_data;
  logic [WIDTH-1:0]      ext_data;
  logic [WIDTH-1:0]      rf_w_data;
  logic [AW-1:0]         rf_w_addr;
  logic                  rf_we, ext_wait, ext_err;

  wb_select_stage #(
    .WIDTH(WIDTH), .NSRC(NSRC), .AW(AW),
    .EXT_IDX(EXT_IDX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .we_in(we_in), .dst_addr_in(dst_addr_in),
    .src_sel(src_sel), .src_data(src_data),
    .ext_valid(ext_valid), .ext_data(ext_data),
    .rf_w_data(rf_w_data), .rf_w_addr(rf_w_addr),
    .rf_we(rf_we), .ext_wait(ext_wait), .ext_err(ext_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [AW-1:0]    a;
    logic             we;
    logic             wt;
    logic             er;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic [WIDTH-1:0] m_d;
  logic [AW-1:0]    m_a;
  logic             m_we, m_wt, m_er;
  bit               m_pending;
  int               m_elapsed;
  logic             m_rec_we;

  function automatic int pick_src(logic [NSRC-1:0] s);
    for (int i = 0; i < NSRC; i++) if (s[i]) return i;
    return 0;
  endfunction

  task automatic model_step();
    int k;
    k = pick_src(src_sel);
    if (rst) begin
      m_d = '0; m_a = '0; m_we = 0; m_wt = 0; m_er = 0;
      m_pending = 0; m_elapsed = 0;
    end else if (!m_pending) begin
      if (flush || stall) begin
        m_we = 0;
      end else if (k == EXT_IDX && !ext_valid) begin
        m_a = dst_addr_in; m_we = 0; m_wt = 1;
        m_pending = 1; m_elapsed = 0; m_rec_we = we_in;
      end else begin
        m_d  = (k == EXT_IDX) ? ext_data : src_data[k*WIDTH +: WIDTH];
        m_a  = dst_addr_in;
        m_we = we_in;
      end
    end else begin
      m_elapsed++;
      if (flush) begin
        m_we = 0; m_wt = 0; m_pending = 0;
      end else if (ext_valid) begin
        m_d = ext_data; m_we = m_rec_we; m_wt = 0; m_pending = 0;
      end else if (m_elapsed == TIMEOUT) begin
        m_er = 1; m_we = 0; m_wt = 0; m_pending = 0;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    exp_q.push_back('{d: m_d, a: m_a, we: m_we, wt: m_wt, er: m_er});
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic chk(bit ok, string what);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cyc%0d %s: d=%h a=%0d we=%b wt=%b er=%b",
               cyc, what, rf_w_data, rf_w_addr,
               rf_we, ext_wait, ext_err);
    end
  endtask

  task automatic idle();
    rst = 0; stall = 0; flush = 0; we_in = 0; ext_valid = 0;
    dst_addr_in = '0; src_sel = '0; ext_data = '0;
  endtask

  task automatic set_src(int i, logic [WIDTH-1:0] v);
    src_data[i*WIDTH +: WIDTH] = v;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({rf_w_data, rf_w_addr, rf_we, ext_wait, ext_err} !== e) begin
        errors++;
        $display("FAIL cyc%0d outputs got d=%h a=%0d we=%b wt=%b er=%b exp d=%h a=%0d we=%b wt=%b er=%b",
                 cyc, rf_w_data, rf_w_addr, rf_we, ext_wait, ext_err,
                 e.d, e.a, e.we, e.wt, e.er);
      end
    end
  end

  initial begin
    idle();
    src_data = '0;
    m_d = '0; m_a = '0; m_we = 0; m_wt = 0; m_er = 0;
    m_pending = 0; m_elapsed = 0; m_rec_we = 0;
    rst = 1; cycle(); cycle();
    chk(rf_w_data === '0 && rf_w_addr === '0 && rf_we === 1'b0 &&
        ext_wait === 1'b0 && ext_err === 1'b0, "reset state");
    idle(); cycle();

    set_src(2, 32'h11111111); set_src(4, 32'h22222222);
    src_sel = 6'b010100; we_in = 1; dst_addr_in = 4'd5; cycle();

    idle(); set_src(0, 32'hDEADBEEF); we_in = 1; dst_addr_in = 4'd1;
    cycle();
    stall = 1; cycle(); cycle();
    idle(); cycle();

    src_sel = 6'b001000; dst_addr_in = 4'd9; we_in = 1; cycle();
    idle(); cycle(); cycle();
    ext_valid = 1; ext_data = 32'hCAFE0001; cycle();
    idle(); cycle();

    src_sel = 6'b001000; dst_addr_in = 4'd3; we_in = 1; cycle();
    idle();
    for (int i = 0; i < TIMEOUT + 1; i++) cycle();
    chk(ext_wait === 1'b0 && ext_err === 1'b1 && rf_we === 1'b0,
        "expired wait");
    set_src(0, 32'h0BADF00D); we_in = 1; dst_addr_in = 4'd7; cycle();
    idle(); rst = 1; cycle();

    idle(); src_sel = 6'b001000; dst_addr_in = 4'd2; we_in = 1; cycle();
    idle(); flush = 1; ext_valid = 1; ext_data = 32'h12345678; cycle();
    idle(); cycle();

    src_sel = 6'b001000; dst_addr_in = 4'd6; we_in = 1; cycle();
    idle(); cycle();
    rst = 1; cycle();
    idle(); ext_valid = 1; ext_data = 32'h55AA55AA; cycle();
    idle(); cycle();

    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 59) == 0);
      flush = ($urandom_range(0, 11) == 0);
      stall = ($urandom_range(0, 7) == 0);
      we_in = $urandom_range(0, 1);
      dst_addr_in = AW'($urandom);
      if ($urandom_range(0, 2) == 0) src_sel = 6'b001000 | NSRC'($urandom & 32'h30);
      else src_sel = NSRC'($urandom);
      for (int i = 0; i < NSRC; i++) set_src(i, $urandom);
      ext_valid = ($urandom_range(0, 4) == 0);
      ext_data  = $urandom;
      cycle();
    end

    idle(); cycle();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
